vga_timing_ctrl: RTL

Video timing controller that sequences the colour-bar pattern source. It produces the pixel-request, new-line and new-frame strobes the source consumes, along with the matching HSYNC/VSYNC/DE outputs. Sync and DE are delayed by a configurable pipeline depth so they line up with the source's registered pixel output. It sits between the pixel-clock domain's top level and the pattern source and gates the whole raster on or off cleanly at frame boundaries.

---
 rtl/vga_timing_pkg.sv | 43 ++++
 rtl/vga_timing_ctrl_if.sv | 29 ++
 rtl/vga_sync_delay.sv | 37 +++
 rtl/vga_timing_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared types, timing defaults and small helpers for the VGA timing controller.
package vga_timing_pkg;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // One delay-line word: sync levels already carry their output polarity.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic de;
  } sync_bits_t;

  // Default 640x480 @ 60 Hz timing.
  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HFP    = 16;
  localparam int DEF_HSW    = 96;
  localparam int DEF_HBP    = 48;
  localparam int DEF_HEIGHT = 480;
  localparam int DEF_VFP    = 10;
  localparam int DEF_VSW    = 2;
  localparam int DEF_VBP    = 33;

  // Total clocks per line.
  function automatic int calc_htotal(int width, int hfp, int hsw, int hbp);
    return width + hfp + hsw + hbp;
  endfunction

  // Total lines per frame.
  function automatic int calc_vtotal(int height, int vfp, int vsw, int vbp);
    return height + vfp + vsw + vbp;
  endfunction

  // True while pos lies inside the sync pulse [start, start+len).
  function automatic logic in_sync_region(int pos, int start, int len);
    return (pos >= start) && (pos < start + len);
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Strobe/sync bundle between the timing controller (master) and the
// pattern source / video output side (slave).
interface vga_timing_ctrl_if #(
  parameter int HW = 12,
  parameter int VW = 12
);
  logic          i_en;
  logic          o_rd;
  logic          o_newline;
  logic          o_newframe;
  logic [HW-1:0] o_hpos;
  logic [VW-1:0] o_vpos;
  logic          o_hsync;
  logic          o_vsync;
  logic          o_de;
  logic          o_busy;

  modport master (
    input  i_en,
    output o_rd, o_newline, o_newframe, o_hpos, o_vpos,
           o_hsync, o_vsync, o_de, o_busy
  );

  modport slave (
    output i_en,
    input  o_rd, o_newline, o_newframe, o_hpos, o_vpos,
           o_hsync, o_vsync, o_de, o_busy
  );
endinterface

// File: rtl/vga_sync_delay.sv
// PIPE-deep shift register aligning hsync/vsync/de with the pattern
// source's registered pixel output. PIPE=0 is a plain wire.
module vga_sync_delay
  import vga_timing_pkg::*;
#(
  parameter int         PIPE    = 2,
  parameter sync_bits_t RST_VAL = '0
) (
  input  logic       i_pixclk,
  input  logic       i_reset_n,
  input  sync_bits_t i_d,
  output sync_bits_t o_q
);

  generate
    if (PIPE == 0) begin : g_pass
      assign o_q = i_d;
    end else begin : g_pipe
      sync_bits_t r_stage [PIPE];

      // Shift the sync word one stage per pixel clock.
      always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          // NOTE: every stage is reset so the outputs sit at their inactive
          // levels the moment reset asserts, not PIPE clocks later.
          for (int i = 0; i < PIPE; i++) r_stage[i] <= RST_VAL;
        end else begin
          r_stage[0] <= i_d;
          for (int i = 1; i < PIPE; i++) r_stage[i] <= r_stage[i-1];
        end
      end

      assign o_q = r_stage[PIPE-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_ctrl.sv
// Raster timing controller: IDLE/PRIME/RUN sequencer, h/v counters,
// source strobes and PIPE-delayed HSYNC/VSYNC/DE.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int HW        = 12,
  parameter int VW        = 12,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int HFP       = DEF_HFP,
  parameter int HSW       = DEF_HSW,
  parameter int HBP       = DEF_HBP,
  parameter int HEIGHT    = DEF_HEIGHT,
  parameter int VFP       = DEF_VFP,
  parameter int VSW       = DEF_VSW,
  parameter int VBP       = DEF_VBP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int PIPE      = 2
) (
  input  logic               i_pixclk,
  input  logic               i_reset_n,
  vga_timing_ctrl_if.master  bus
);

  localparam int HTOTAL = calc_htotal(WIDTH, HFP, HSW, HBP);
  localparam int VTOTAL = calc_vtotal(HEIGHT, VFP, VSW, VBP);

  localparam logic [HW-1:0] H_LAST = HW'(HTOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(VTOTAL - 1);

  localparam sync_bits_t SYNC_IDLE = '{hsync: ~HSYNC_POL, vsync: ~VSYNC_POL, de: 1'b0};

  generate
    if (HTOTAL > (1 << HW)) begin : g_err_htotal
      $error("HTOTAL does not fit in HW bits");
    end
    if (VTOTAL > (1 << VW)) begin : g_err_vtotal
      $error("VTOTAL does not fit in VW bits");
    end
    if (PIPE < 0 || PIPE > 7) begin : g_err_pipe
      $error("PIPE must be in 0..7");
    end
  endgenerate

  state_e        r_state;
  logic [HW-1:0] r_hcount;
  logic [VW-1:0] r_vcount;
  logic          r_stop_pend;
  logic          r_rd;
  logic          r_newline;
  logic          r_newframe;
  logic          r_busy;
  logic          r_hs_raw;
  logic          r_vs_raw;

  state_e        w_state_nxt;
  logic [HW-1:0] w_hcount_nxt;
  logic [VW-1:0] w_vcount_nxt;
  logic          w_stop_pend_nxt;
  logic          w_h_last;
  logic          w_v_last;
  logic          w_run_nxt;
  logic          w_prime_nxt;
  logic          w_hlast_nxt;
  logic          w_vlast_nxt;

  sync_bits_t    w_sync_raw;
  sync_bits_t    w_sync_dly;

  assign w_h_last = (r_hcount == H_LAST);
  assign w_v_last = (r_vcount == V_LAST);

  // Next state, counters and stop request from the current registered state.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    w_state_nxt     = r_state;
    w_hcount_nxt    = r_hcount;
    w_vcount_nxt    = r_vcount;
    w_stop_pend_nxt = r_stop_pend;
    case (r_state)
      ST_IDLE: begin
        w_hcount_nxt    = '0;
        w_vcount_nxt    = '0;
        w_stop_pend_nxt = 1'b0;
        if (bus.i_en) w_state_nxt = ST_PRIME;
      end
      ST_PRIME: begin
        w_hcount_nxt    = '0;
        w_vcount_nxt    = '0;
        w_stop_pend_nxt = 1'b0;
        w_state_nxt     = ST_RUN;
      end
      ST_RUN: begin
        w_stop_pend_nxt = ~bus.i_en;
        if (w_h_last) begin
          w_hcount_nxt = '0;
          if (w_v_last) begin
            w_vcount_nxt = '0;
            if (r_stop_pend) begin
              w_state_nxt     = ST_IDLE;
              w_stop_pend_nxt = 1'b0;
            end
          end else begin
            w_vcount_nxt = r_vcount + VW'(1);
          end
        end else begin
          w_hcount_nxt = r_hcount + HW'(1);
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_hcount_nxt    = '0;
        w_vcount_nxt    = '0;
        w_stop_pend_nxt = 1'b0;
      end
    endcase
  end

  // Strobes are decoded from the next-cycle values so the registered
  // outputs line up with the counters they are registered alongside.
  assign w_run_nxt   = (w_state_nxt == ST_RUN);
  assign w_prime_nxt = (w_state_nxt == ST_PRIME);
  assign w_hlast_nxt = (w_hcount_nxt == H_LAST);
  assign w_vlast_nxt = (w_vcount_nxt == V_LAST);

  // Sequencer, counters and registered strobe/raw-sync outputs.
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= ST_IDLE;
      r_hcount    <= '0;
      r_vcount    <= '0;
      r_stop_pend <= 1'b0;
      r_rd        <= 1'b0;
      r_newline   <= 1'b0;
      r_newframe  <= 1'b0;
      r_busy      <= 1'b0;
      r_hs_raw    <= 1'b0;
      r_vs_raw    <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every register here samples the
      // pre-edge values regardless of statement order.
      r_state     <= w_state_nxt;
      r_hcount    <= w_hcount_nxt;
      r_vcount    <= w_vcount_nxt;
      r_stop_pend <= w_stop_pend_nxt;
      r_rd        <= w_run_nxt && (int'(w_hcount_nxt) < WIDTH)
                               && (int'(w_vcount_nxt) < HEIGHT);
      r_newline   <= w_prime_nxt || (w_run_nxt && w_hlast_nxt);
      r_newframe  <= w_prime_nxt || (w_run_nxt && w_hlast_nxt && w_vlast_nxt);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_hs_raw    <= w_run_nxt && in_sync_region(int'(w_hcount_nxt), WIDTH + HFP, HSW);
      r_vs_raw    <= w_run_nxt && in_sync_region(int'(w_vcount_nxt), HEIGHT + VFP, VSW);
    end
  end

  // Apply output polarity before the delay line so its reset value is
  // simply the inactive level.
  assign w_sync_raw.hsync = r_hs_raw ? HSYNC_POL : ~HSYNC_POL;
  assign w_sync_raw.vsync = r_vs_raw ? VSYNC_POL : ~VSYNC_POL;
  assign w_sync_raw.de    = r_rd;

  vga_sync_delay #(
    .PIPE    (PIPE),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .i_pixclk  (i_pixclk),
    .i_reset_n (i_reset_n),
    .i_d       (w_sync_raw),
    .o_q       (w_sync_dly)
  );

  assign bus.o_rd       = r_rd;
  assign bus.o_newline  = r_newline;
  assign bus.o_newframe = r_newframe;
  assign bus.o_hpos     = r_hcount;
  assign bus.o_vpos     = r_vcount;
  assign bus.o_busy     = r_busy;
  assign bus.o_hsync    = w_sync_dly.hsync;
  assign bus.o_vsync    = w_sync_dly.vsync;
  assign bus.o_de       = w_sync_dly.de;

endmodule
